cr_xp10_comp_bit_pack: RTL and testbench



---
 rtl/cr_xp10_comp_bit_pack_if.sv | 30 +++
 rtl/cr_xp10_comp_bit_pack.sv | 173 +++++++++++++++++
 tb/tb_cr_xp10_comp_bit_pack.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/cr_xp10_comp_bit_pack_if.sv
// Bundle of the encoder-side code stream and the packed-word output stream of the XP10 bit packer.
// The design attaches through the slave modport, and the encoder/output stage attaches through the master modport.
interface cr_xp10_comp_bit_pack_if;
    logic        enc_bp_valid;
    logic [31:0] enc_bp_code;
    logic [5:0]  enc_bp_len;
    logic        enc_bp_eob;
    logic        enc_bp_eof;
    logic        bp_enc_ready;
    logic        bp_out_valid;
    logic [63:0] bp_out_data;
    logic [3:0]  bp_out_bytes;
    logic        bp_out_eof;
    logic [27:0] bp_out_frame_bytes;
    logic        bp_out_ready;
    logic        bp_err_stb;
    logic        bp_stall_stb;

    modport slave (
        input  enc_bp_valid, enc_bp_code, enc_bp_len, enc_bp_eob, enc_bp_eof, bp_out_ready,
        output bp_enc_ready, bp_out_valid, bp_out_data, bp_out_bytes, bp_out_eof,
               bp_out_frame_bytes, bp_err_stb, bp_stall_stb
    );

    modport master (
        output enc_bp_valid, enc_bp_code, enc_bp_len, enc_bp_eob, enc_bp_eof, bp_out_ready,
        input  bp_enc_ready, bp_out_valid, bp_out_data, bp_out_bytes, bp_out_eof,
               bp_out_frame_bytes, bp_err_stb, bp_stall_stb
    );
endinterface

// File: rtl/cr_xp10_comp_bit_pack.sv
// XP10 compression bit packer: packs variable-length codes LSB-first into 64-bit words, with frame flush and byte count.
// Optional: define CR_XP10_COMP_BP_EOB_ALIGN_EN to byte-align the stream after each end-of-block code.
module cr_xp10_comp_bit_pack #(
    parameter int OUT_W         = 64,
    parameter int MAX_CODE_BITS = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cr_xp10_comp_bit_pack_if.slave  bp
);

    localparam int ACC_W = OUT_W + MAX_CODE_BITS;

    typedef enum logic {ST_PACK, ST_FLUSH} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [6:0]         fill_q, fill_d;
    logic [27:0]        frame_cnt_q, frame_cnt_d;

    logic               out_valid_q;
    logic [OUT_W-1:0]   out_data_q;
    logic [3:0]         out_bytes_q;
    logic               out_eof_q;
    logic [27:0]        out_frame_bytes_q;
    logic               err_q;
    logic               stall_q;

    logic               slot_free;
    logic               has_word;
    logic               emit_full;
    logic [ACC_W-1:0]   acc_shift;
    logic [6:0]         fill_shift;
    logic               len_illegal;
    logic [5:0]         len_eff;
    logic [31:0]        code_mask;
    logic [ACC_W-1:0]   code_ins;
    logic [6:0]         fill_app;
    logic [6:0]         fill_new;
    logic               enc_ready;
    logic               accept;

    logic               load;
    logic [OUT_W-1:0]   load_data;
    logic [3:0]         load_bytes;
    logic               load_eof;
    logic [28:0]        frame_sum;
    logic [27:0]        frame_sat;

    // A full word leaves whenever the output slot is free; the same cycle may also append a new code.
    assign slot_free   = !out_valid_q || bp.bp_out_ready;
    assign has_word    = fill_q >= 7'd64;
    assign emit_full   = has_word && slot_free;
    assign acc_shift   = emit_full ? (acc_q >> OUT_W) : acc_q;
    assign fill_shift  = emit_full ? (fill_q - 7'd64) : fill_q;

    assign len_illegal = bp.enc_bp_len > 6'd32;
    assign len_eff     = len_illegal ? 6'd32 : bp.enc_bp_len;
    assign code_mask   = ~(32'hFFFF_FFFF << len_eff);
    assign code_ins    = {{(ACC_W-32){1'b0}}, bp.enc_bp_code & code_mask} << fill_shift;
    assign fill_app    = fill_shift + {1'b0, len_eff};

`ifdef CR_XP10_COMP_BP_EOB_ALIGN_EN
    // Pad bits above fill are already zero, so rounding fill up is all the alignment needs.
    assign fill_new    = (bp.enc_bp_eob && !bp.enc_bp_eof) ? ((fill_app + 7'd7) & 7'h78) : fill_app;
`else
    logic unused_eob;
    assign unused_eob  = bp.enc_bp_eob;
    assign fill_new    = fill_app;
`endif

    assign enc_ready   = (state_q == ST_PACK) && (!has_word || slot_free);
    assign accept      = bp.enc_bp_valid && enc_ready;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        fill_d      = fill_q;
        frame_cnt_d = frame_cnt_q;
        load        = 1'b0;
        load_data   = '0;
        load_bytes  = 4'd0;
        load_eof    = 1'b0;

        if (emit_full) begin
            load       = 1'b1;
            load_data  = acc_q[OUT_W-1:0];
            load_bytes = 4'd8;
            acc_d      = acc_shift;
            fill_d     = fill_shift;
        end

        case (state_q)
            ST_PACK: begin
                if (accept) begin
                    acc_d  = acc_shift | code_ins;
                    fill_d = fill_new;
                    if (bp.enc_bp_eof) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                // The last partial (possibly empty) word closes the frame and restarts packing at bit 0.
                if (!has_word && slot_free) begin
                    load       = 1'b1;
                    load_data  = acc_q[OUT_W-1:0];
                    load_bytes = 4'((fill_q + 7'd7) >> 3);
                    load_eof   = 1'b1;
                    acc_d      = '0;
                    fill_d     = 7'd0;
                    state_d    = ST_PACK;
                end
            end
            default: state_d = ST_PACK;
        endcase

        frame_sum = {1'b0, frame_cnt_q} + {25'd0, load_bytes};
        frame_sat = frame_sum[28] ? 28'hFFF_FFFF : frame_sum[27:0];
        if (load) begin
            frame_cnt_d = load_eof ? 28'd0 : frame_sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PACK;
            acc_q       <= '0;
            fill_q      <= 7'd0;
            frame_cnt_q <= 28'd0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Output register only reloads into a free slot, so a stalled beat stays intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q       <= 1'b0;
            out_data_q        <= '0;
            out_bytes_q       <= 4'd0;
            out_eof_q         <= 1'b0;
            out_frame_bytes_q <= 28'd0;
            err_q             <= 1'b0;
            stall_q           <= 1'b0;
        end else begin
            if (load) begin
                out_valid_q       <= 1'b1;
                out_data_q        <= load_data;
                out_bytes_q       <= load_bytes;
                out_eof_q         <= load_eof;
                out_frame_bytes_q <= frame_sat;
            end else if (bp.bp_out_ready) begin
                out_valid_q       <= 1'b0;
            end
            err_q   <= accept && len_illegal;
            stall_q <= bp.enc_bp_valid && !enc_ready;
        end
    end

    assign bp.bp_enc_ready       = enc_ready;
    assign bp.bp_out_valid       = out_valid_q;
    assign bp.bp_out_data        = out_data_q;
    assign bp.bp_out_bytes       = out_bytes_q;
    assign bp.bp_out_eof         = out_eof_q;
    assign bp.bp_out_frame_bytes = out_frame_bytes_q;
    assign bp.bp_err_stb         = err_q;
    assign bp.bp_stall_stb       = stall_q;

endmodule

// File: tb/tb_cr_xp10_comp_bit_pack.sv
// Directed bench for cr_xp10_comp_bit_pack: expected output beats are queued as codes are driven and
// compared as each beat is handed off downstream.
module tb_cr_xp10_comp_bit_pack;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  bytes;
        logic        eof;
        logic [27:0] frameBytes;
    } beat_t;

    logic  clk;
    logic  rst_n;
    beat_t expQ[$];
    int    checks      = 0;
    int    errors      = 0;
    int    beatIdx     = 0;
    int    errPulses   = 0;
    int    stallPulses = 0;
    int    readyLow    = 0;

    cr_xp10_comp_bit_pack_if bus();

    cr_xp10_comp_bit_pack dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expectBeat(input logic [63:0] data, input logic [3:0] bytes, input logic eof,
                              input logic [27:0] frameBytes);
        beat_t b;
        b.data       = data;
        b.bytes      = bytes;
        b.eof        = eof;
        b.frameBytes = frameBytes;
        expQ.push_back(b);
    endtask

    // Holds one code on the bus until it is accepted; returns just after the accepting edge.
    task automatic applyStimulus(input logic [31:0] code, input logic [5:0] len, input logic eob,
                                 input logic eof);
        int n;
        bus.enc_bp_valid = 1'b1;
        bus.enc_bp_code  = code;
        bus.enc_bp_len   = len;
        bus.enc_bp_eob   = eob;
        bus.enc_bp_eof   = eof;
        n = 0;
        @(negedge clk);
        while (!bus.bp_enc_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (bus.bp_enc_ready === 1'b1) else begin
            errors++;
            $error("[TB] FAIL accept_timeout observed_ready=%0b expected_ready=1 code=0x%0h", bus.bp_enc_ready, code);
        end
        @(posedge clk);
        #1;
        bus.enc_bp_valid = 1'b0;
        bus.enc_bp_eob   = 1'b0;
        bus.enc_bp_eof   = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        checkOutput({tag, "_drain_left"}, 64'(expQ.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"},  64'(bus.bp_out_valid),       64'd0);
        checkOutput({tag, "_data"},   bus.bp_out_data,             64'd0);
        checkOutput({tag, "_bytes"},  64'(bus.bp_out_bytes),       64'd0);
        checkOutput({tag, "_eof"},    64'(bus.bp_out_eof),         64'd0);
        checkOutput({tag, "_fbytes"}, 64'(bus.bp_out_frame_bytes), 64'd0);
        checkOutput({tag, "_err"},    64'(bus.bp_err_stb),         64'd0);
        checkOutput({tag, "_stall"},  64'(bus.bp_stall_stb),       64'd0);
        checkOutput({tag, "_ready"},  64'(bus.bp_enc_ready),       64'd1);
    endtask

    // Scoreboard side: a beat is consumed at the edge following a negedge where valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.bp_err_stb) errPulses++;
            if (bus.bp_stall_stb) stallPulses++;
            if (bus.enc_bp_valid && !bus.bp_enc_ready) readyLow++;
            if (bus.bp_out_valid && bus.bp_out_ready) begin
                checks++;
                assert (expQ.size() != 0) else begin
                    errors++;
                    $error("[TB] FAIL unexpected_beat observed_data=0x%0h expected=none", bus.bp_out_data);
                end
                if (expQ.size() != 0) begin
                    beat_t e;
                    e = expQ.pop_front();
                    checkOutput($sformatf("beat%0d_data", beatIdx),   bus.bp_out_data,             e.data);
                    checkOutput($sformatf("beat%0d_bytes", beatIdx),  64'(bus.bp_out_bytes),       64'(e.bytes));
                    checkOutput($sformatf("beat%0d_eof", beatIdx),    64'(bus.bp_out_eof),         64'(e.eof));
                    checkOutput($sformatf("beat%0d_fbytes", beatIdx), 64'(bus.bp_out_frame_bytes), 64'(e.frameBytes));
                end
                beatIdx++;
            end
        end
    end

    initial begin
        int stallBefore;
        int readyLowBefore;
        logic [31:0] c [10];

        rst_n            = 1'b0;
        bus.enc_bp_valid = 1'b0;
        bus.enc_bp_code  = 32'd0;
        bus.enc_bp_len   = 6'd0;
        bus.enc_bp_eob   = 1'b0;
        bus.enc_bp_eof   = 1'b0;
        bus.bp_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single short code with eof");
        expectBeat(64'h5, 4'd1, 1'b1, 28'd1);
        applyStimulus(32'b101, 6'd3, 1'b0, 1'b1);
        waitDrain("t1");

        $display("[TB] two full-width codes, empty terminator");
        expectBeat(64'h12345678_FFFFFFFF, 4'd8, 1'b0, 28'd8);
        expectBeat(64'h0, 4'd0, 1'b1, 28'd8);
        applyStimulus(32'hFFFF_FFFF, 6'd32, 1'b0, 1'b0);
        applyStimulus(32'h1234_5678, 6'd32, 1'b0, 1'b1);
        waitDrain("t2");

        $display("[TB] backpressure for 20 cycles over ten codes");
        for (int i = 0; i < 10; i++) c[i] = 32'hA5A5_0000 | 32'(i * 17 + 3);
        for (int i = 0; i < 5; i++) expectBeat({c[2*i+1], c[2*i]}, 4'd8, 1'b0, 28'(8 * (i + 1)));
        expectBeat(64'h0, 4'd0, 1'b1, 28'd40);
        stallBefore      = stallPulses;
        readyLowBefore   = readyLow;
        bus.bp_out_ready = 1'b0;
        fork
            begin
                repeat (20) @(posedge clk);
                #1;
                bus.bp_out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 10; i++) applyStimulus(c[i], 6'd32, 1'b0, i == 9);
        waitDrain("t3");
        checks++;
        assert (readyLow > readyLowBefore) else begin
            errors++;
            $error("[TB] FAIL ready_drop observed=%0d expected>%0d", readyLow, readyLowBefore);
        end
        checks++;
        assert (stallPulses > stallBefore) else begin
            errors++;
            $error("[TB] FAIL stall_stb observed=%0d expected>%0d", stallPulses, stallBefore);
        end

        $display("[TB] eob followed by eof");
`ifdef CR_XP10_COMP_BP_EOB_ALIGN_EN
        expectBeat(64'hA1F, 4'd2, 1'b1, 28'd2);
`else
        expectBeat(64'h15F, 4'd2, 1'b1, 28'd2);
`endif
        applyStimulus(32'h1F, 6'd5, 1'b1, 1'b0);
        applyStimulus(32'hA, 6'd4, 1'b0, 1'b1);
        waitDrain("t4");

        $display("[TB] partial tail with junk above len");
        expectBeat(64'h01234567_DEADBEEF, 4'd8, 1'b0, 28'd8);
        expectBeat(64'hABC, 4'd2, 1'b1, 28'd10);
        applyStimulus(32'hDEAD_BEEF, 6'd32, 1'b0, 1'b0);
        applyStimulus(32'h0123_4567, 6'd32, 1'b0, 1'b0);
        applyStimulus(32'hFFFF_FABC, 6'd12, 1'b0, 1'b1);
        waitDrain("t5");

        $display("[TB] reset mid-frame with a stalled word");
        bus.bp_out_ready = 1'b0;
        applyStimulus(32'h1122_3344, 6'd32, 1'b0, 1'b0);
        applyStimulus(32'h5566_7788, 6'd32, 1'b0, 1'b0);
        applyStimulus(32'h99, 6'd8, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("midframe_valid", 64'(bus.bp_out_valid), 64'd1);
        rst_n = 1'b0;
        #2;
        checkResetState("midreset");
        bus.bp_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expectBeat(64'hC3, 4'd1, 1'b1, 28'd1);
        applyStimulus(32'hC3, 6'd8, 1'b0, 1'b1);
        waitDrain("t6");

        $display("[TB] illegal length clamps to 32");
        expectBeat(64'hFFFF_FFFF, 4'd4, 1'b1, 28'd4);
        applyStimulus(32'hFFFF_FFFF, 6'd40, 1'b0, 1'b1);
        checkOutput("err_pulse", 64'(bus.bp_err_stb), 64'd1);
        @(posedge clk);
        #1;
        checkOutput("err_clear", 64'(bus.bp_err_stb), 64'd0);
        waitDrain("t7");
        checkOutput("err_total", 64'(errPulses), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
